// File: rtl/dbg_trace_buf.sv
// Commit trace buffer: captures retired instructions into a circular store, freezes a
// programmable number of commits after an ebreak/invalid-instruction event, drains in order.
module dbg_trace_buf #(
  parameter int XLEN     = 32,
  parameter int RAW      = 5,
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 4,
  parameter int WRAP     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done,
  input  logic [XLEN-1:0]            pc,
  input  logic [XLEN-1:0]            inst,
  input  logic                       brk,
  input  logic                       ivd,
  input  logic                       gpr_wen,
  input  logic [RAW-1:0]             gpr_waddr,
  input  logic [XLEN-1:0]            gpr_wdata,
  input  logic                       arm,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_inst,
  output logic                       rd_wen,
  output logic [RAW-1:0]             rd_waddr,
  output logic [XLEN-1:0]            rd_wdata,
  output logic [1:0]                 rd_cause,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic [15:0]                dropped,
  output logic [31:0]                commit_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_POST   = 2'b10,
    S_FROZEN = 2'b11
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            wen;
    logic [RAW-1:0]  waddr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      cause;
  } entry_t;

  entry_t        r_mem [DEPTH];
  state_t        r_state, w_state_next;
  logic [AW-1:0] r_post, w_post_next;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_dropped;
  logic [31:0]   r_commit_cnt;

  logic   w_capture, w_full, w_pop, w_write, w_drop, w_adv_head, w_inc, w_dec;
  entry_t w_entry, w_head;

  assign w_capture  = done && (r_state == S_RUN || r_state == S_POST) && !arm;
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = (r_count != '0) && rd_ready && !arm;
  // A concurrent pop always frees the slot the new record lands in, even when full.
  assign w_write    = w_capture && (!w_full || w_pop || (WRAP != 0));
  assign w_drop     = w_capture && w_full && !w_pop;
  assign w_adv_head = w_pop || (w_drop && (WRAP != 0));
  assign w_inc      = w_write && !w_pop && !w_full;
  assign w_dec      = w_pop && !w_write;

  assign w_entry = '{pc: pc, inst: inst, wen: gpr_wen && done, waddr: gpr_waddr,
                     wdata: gpr_wdata, cause: {ivd, brk}};

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_post       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dropped    <= '0;
      r_commit_cnt <= '0;
    end else if (arm) begin
      r_state      <= w_state_next;
      r_post       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dropped    <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_post  <= w_post_next;
      if (w_write)    r_wptr <= r_wptr + 1'b1;
      if (w_adv_head) r_rptr <= r_rptr + 1'b1;
      if (w_inc)      r_count <= r_count + 1'b1;
      else if (w_dec) r_count <= r_count - 1'b1;
      if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      if (done) r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  // The trigger commit itself never decrements the post counter.
  always_comb begin
    w_state_next = r_state;
    w_post_next  = r_post;
    if (arm) begin
      w_state_next = S_RUN;
      w_post_next  = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_capture && (brk || ivd)) begin
            if (POST_CNT == 0) begin
              w_state_next = S_FROZEN;
            end else begin
              w_state_next = S_POST;
              w_post_next  = AW'(POST_CNT);
            end
          end
        end
        S_POST: begin
          if (w_capture) begin
            w_post_next = r_post - 1'b1;
            if (r_post == AW'(1)) w_state_next = S_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign rd_valid   = (r_count != '0);
  assign rd_pc      = rd_valid ? w_head.pc    : '0;
  assign rd_inst    = rd_valid ? w_head.inst  : '0;
  assign rd_wen     = rd_valid ? w_head.wen   : 1'b0;
  assign rd_waddr   = rd_valid ? w_head.waddr : '0;
  assign rd_wdata   = rd_valid ? w_head.wdata : '0;
  assign rd_cause   = rd_valid ? w_head.cause : 2'b00;
  assign count      = r_count;
  assign state      = r_state;
  assign dropped    = r_dropped;
  assign commit_cnt = r_commit_cnt;
endmodule

// File: tb/tb_dbg_trace_buf.sv
// Directed bench for dbg_trace_buf: a flight-recorder instance and a stop-on-full
// instance driven by the same stimulus, checked against hand-computed values.
module tb_dbg_trace_buf;
  logic        clk = 1'b0;
  logic        reset, done, brk, ivd, gpr_wen, arm, rd_ready;
  logic [31:0] pc, inst, gpr_wdata;
  logic [4:0]  gpr_waddr;

  logic        rd_valid, rd_wen;
  logic [31:0] rd_pc, rd_inst, rd_wdata, commit_cnt;
  logic [4:0]  rd_waddr, count;
  logic [1:0]  rd_cause, state;
  logic [15:0] dropped;

  logic        n_rd_valid, n_rd_wen;
  logic [31:0] n_rd_pc, n_rd_inst, n_rd_wdata, n_commit_cnt;
  logic [4:0]  n_rd_waddr, n_count;
  logic [1:0]  n_rd_cause, n_state;
  logic [15:0] n_dropped;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbg_trace_buf #(.XLEN(32), .RAW(5), .DEPTH(16), .POST_CNT(4), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .done(done), .pc(pc), .inst(inst), .brk(brk), .ivd(ivd),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .arm(arm),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
    .rd_wen(rd_wen), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_cause(rd_cause),
    .count(count), .state(state), .dropped(dropped), .commit_cnt(commit_cnt)
  );

  dbg_trace_buf #(.XLEN(32), .RAW(5), .DEPTH(16), .POST_CNT(4), .WRAP(0)) dut_nw (
    .clk(clk), .reset(reset), .done(done), .pc(pc), .inst(inst), .brk(brk), .ivd(ivd),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .arm(arm),
    .rd_ready(rd_ready), .rd_valid(n_rd_valid), .rd_pc(n_rd_pc), .rd_inst(n_rd_inst),
    .rd_wen(n_rd_wen), .rd_waddr(n_rd_waddr), .rd_wdata(n_rd_wdata), .rd_cause(n_rd_cause),
    .count(n_count), .state(n_state), .dropped(n_dropped), .commit_cnt(n_commit_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] a, input logic b, input logic v);
    done      = 1'b1;
    pc        = a;
    inst      = ~a;
    brk       = b;
    ivd       = v;
    gpr_wen   = 1'b1;
    gpr_waddr = a[6:2];
    gpr_wdata = a + 32'h1;
    step();
    done    = 1'b0;
    brk     = 1'b0;
    ivd     = 1'b0;
    gpr_wen = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b1; done = 1'b0; brk = 1'b0; ivd = 1'b0; gpr_wen = 1'b0; arm = 1'b0;
    rd_ready = 1'b0; pc = '0; inst = '0; gpr_wdata = '0; gpr_waddr = '0;
    step(); step();
    reset = 1'b0;
    step();

    check_val("rst_state", state, 2'b00);
    check_val("rst_count", count, 0);
    check_val("rst_valid", rd_valid, 0);
    check_val("rst_rd_pc", rd_pc, 0);
    check_val("rst_dropped", dropped, 0);
    check_val("rst_commit_cnt", commit_cnt, 0);

    // A commit while idle is counted but not captured
    commit(32'h0000_0100, 1'b0, 1'b0);
    check_val("idle_count", count, 0);
    check_val("idle_commit_cnt", commit_cnt, 1);

    // Basic in-order capture and drain
    do_arm();
    check_val("arm_state", state, 2'b01);
    check_val("arm_commit_cnt", commit_cnt, 0);
    commit(32'h8000_0000, 1'b0, 1'b0);
    commit(32'h8000_0004, 1'b0, 1'b0);
    commit(32'h8000_0008, 1'b0, 1'b0);
    check_val("basic_count", count, 3);
    check_val("basic_inst", rd_inst, 32'h7FFF_FFFF);
    check_val("basic_wen", rd_wen, 1);
    check_val("basic_wdata", rd_wdata, 32'h8000_0001);
    check_val("basic_cause", rd_cause, 2'b00);
    rd_ready = 1'b1;
    check_val("basic_pc0", rd_pc, 32'h8000_0000);
    step();
    check_val("basic_pc1", rd_pc, 32'h8000_0004);
    step();
    check_val("basic_pc2", rd_pc, 32'h8000_0008);
    check_val("basic_waddr2", rd_waddr, 5'd2);
    step();
    rd_ready = 1'b0;
    check_val("basic_empty_count", count, 0);
    check_val("basic_empty_valid", rd_valid, 0);
    check_val("basic_empty_pc", rd_pc, 0);
    check_val("basic_dropped", dropped, 0);
    check_val("basic_commit_cnt", commit_cnt, 3);

    // 20 commits into 16 entries, no drain
    do_arm();
    for (int i = 0; i < 20; i++) commit(32'h0000_1000 + 32'(4 * i), 1'b0, 1'b0);
    check_val("wrap_count", count, 16);
    check_val("wrap_dropped", dropped, 4);
    check_val("wrap_head_pc", rd_pc, 32'h0000_1010);
    check_val("stop_count", n_count, 16);
    check_val("stop_dropped", n_dropped, 4);
    check_val("stop_head_pc", n_rd_pc, 32'h0000_1000);

    // Push and pop on a full buffer
    rd_ready = 1'b1;
    commit(32'h0000_2000, 1'b0, 1'b0);
    rd_ready = 1'b0;
    check_val("fullpp_count", count, 16);
    check_val("fullpp_dropped", dropped, 4);
    check_val("fullpp_head_pc", rd_pc, 32'h0000_1014);
    check_val("stop_fullpp_count", n_count, 16);
    check_val("stop_fullpp_dropped", n_dropped, 4);
    check_val("stop_fullpp_head_pc", n_rd_pc, 32'h0000_1004);

    // brk on commit 7, 10 further commits; freezes after commit 11
    do_arm();
    for (int k = 1; k <= 17; k++) begin
      commit(32'h0000_3000 + 32'(4 * (k - 1)), (k == 7), 1'b0);
      if (k == 7)  check_val("post_state_c7", state, 2'b10);
      if (k == 10) check_val("post_state_c10", state, 2'b10);
      if (k == 11) check_val("frozen_state_c11", state, 2'b11);
    end
    check_val("frozen_state", state, 2'b11);
    check_val("frozen_count", count, 11);
    check_val("frozen_commit_cnt", commit_cnt, 17);
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    rd_ready = 1'b0;
    check_val("entry7_pc", rd_pc, 32'h0000_3018);
    check_val("entry7_cause", rd_cause, 2'b01);
    check_val("entry7_count", count, 5);

    // arm with a concurrent commit while frozen
    arm = 1'b1;
    commit(32'h0000_5000, 1'b0, 1'b0);
    arm = 1'b0;
    check_val("rearm_state", state, 2'b01);
    check_val("rearm_count", count, 0);
    check_val("rearm_commit_cnt", commit_cnt, 0);

    // ivd trigger, then reset in the middle of POST
    commit(32'h0000_4000, 1'b0, 1'b1);
    check_val("ivd_state", state, 2'b10);
    check_val("ivd_cause", rd_cause, 2'b10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("rstpost_state", state, 2'b00);
    check_val("rstpost_count", count, 0);
    check_val("rstpost_valid", rd_valid, 0);
    check_val("rstpost_commit_cnt", commit_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
